// File: rtl/nlprg_pkg.sv
// Shared definitions for the nlprg7 word-stream sequencer and arbiter.
package nlprg_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_PRST = 2'd0,
        ST_WARM = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // Cycles spent in WARM after the generator reset is released
    localparam int WARM_CYC = 2;

    // Round-robin pointer after a grant: the requester just past the winner
    function automatic int rr_next_ptr(input int win_idx, input int n_req);
        return (win_idx + 1 >= n_req) ? 0 : win_idx + 1;
    endfunction

endpackage

// File: rtl/nlprg_rr_arb.sv
// Combinational round-robin pick: first asserted request at or after ptr.
module nlprg_rr_arb #(
    parameter int R  = 4,
    parameter int PW = 2
) (
    input  logic [R-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [R-1:0]  win,
    output logic [PW-1:0] win_idx,
    output logic          any
);

    // Walk the requesters starting at ptr, wrapping, and stop at the first hit
    always_comb begin
        win     = '0;
        win_idx = '0;
        any     = 1'b0;
        for (int i = 0; i < R; i++) begin
            if (!any && req[(int'(ptr) + i) % R]) begin
                any                       = 1'b1;
                win[(int'(ptr) + i) % R]  = 1'b1;
                win_idx                   = PW'((int'(ptr) + i) % R);
            end
        end
    end

endmodule

// File: rtl/nlprg_arb.sv
// Sequencer and round-robin arbiter sharing one nlprg7 word stream.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_PRST | generator held in reset (prng_rst=1), cnt held at 0
//   ST_WARM | generator running, cnt counting, no grants or checks yet
//   ST_RUN  | ready=1, words granted round-robin, period monitored
//
// The reset interval itself is not counted as a PRST cycle, so after rst_n
// releases prng_rst stays high for PRST_CYC clock edges; a restart_i pulse
// raises prng_rst at the next edge and that edge counts as the first one.
module nlprg_arb
    import nlprg_pkg::*;
#(
    parameter int N        = 7,
    parameter int R        = 4,
    parameter int PRST_CYC = 2
) (
    input  logic         ck,
    input  logic         rst_n,
    input  logic         restart_i,
    input  logic [R-1:0] req,
    input  logic [N-1:0] prng_o,
    output logic         prng_rst,
    output logic [R-1:0] gnt,
    output logic [N-1:0] rnd_o,
    output logic         ready,
    output logic         period_ok,
    output logic         period_err
);

    localparam int PW = $clog2(R);
    localparam int TW = $clog2(PRST_CYC + WARM_CYC + 1);

    state_t         state;
    logic [TW-1:0]  tmr;
    logic [N-1:0]   cnt;
    logic [PW-1:0]  ptr;
    logic [R-1:0]   win;
    logic [PW-1:0]  win_idx;
    logic           win_any;
    logic           arb_en;
    logic           prng_zero;
    logic           cnt_zero;

    // Grants are issued on edges that land in RUN, including the WARM->RUN edge
    assign arb_en    = !restart_i && ((state == ST_RUN) ||
                                      (state == ST_WARM && tmr == '0));
    assign prng_zero = (prng_o == '0);
    assign cnt_zero  = (cnt == '0);

    nlprg_rr_arb #(
        .R  (R),
        .PW (PW)
    ) u_rr (
        .req     (req),
        .ptr     (ptr),
        .win     (win),
        .win_idx (win_idx),
        .any     (win_any)
    );

    // Sequencer FSM with down-counting phase timer, prng_rst and ready
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_PRST;
            tmr      <= TW'(PRST_CYC);
            prng_rst <= 1'b1;
            ready    <= 1'b0;
        end else if (restart_i) begin
            state    <= ST_PRST;
            tmr      <= TW'(PRST_CYC - 1);
            prng_rst <= 1'b1;
            ready    <= 1'b0;
        end else begin
            case (state)
                ST_PRST: begin
                    if (tmr == '0) begin
                        state    <= ST_WARM;
                        tmr      <= TW'(WARM_CYC - 1);
                        prng_rst <= 1'b0;
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
                ST_WARM: begin
                    if (tmr == '0) begin
                        state <= ST_RUN;
                        ready <= 1'b1;
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
                ST_RUN: begin
                    ready <= 1'b1;
                end
                default: begin
                    state    <= ST_PRST;
                    tmr      <= TW'(PRST_CYC - 1);
                    prng_rst <= 1'b1;
                    ready    <= 1'b0;
                end
            endcase
        end
    end

    // Cycle counter tracking the generator, plus the period monitor
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            period_ok  <= 1'b0;
            period_err <= 1'b0;
        end else begin
            period_ok <= 1'b0;
            if (restart_i || state == ST_PRST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + N'(1);
            end
            if (restart_i) begin
                period_err <= 1'b0;
            end else if (state == ST_RUN) begin
                if (prng_zero && cnt_zero) begin
                    period_ok <= 1'b1;
                end else if (prng_zero != cnt_zero) begin
                    period_err <= 1'b1;
                end
            end
        end
    end

    // Grant register: one requester per word, pointer advances past the winner
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            gnt   <= '0;
            rnd_o <= '0;
            ptr   <= '0;
        end else if (arb_en && win_any) begin
            gnt   <= win;
            rnd_o <= prng_o;
            ptr   <= PW'(rr_next_ptr(int'(win_idx), R));
        end else begin
            gnt <= '0;
        end
    end

endmodule
